// File: rtl/mmio_bus_arbiter_pkg.sv
// Shared types and region map for the two-master MMIO bus arbiter.
package mmio_bus_arbiter_pkg;

  typedef enum logic [1:0] {StIdle, StIssue, StWait, StDone} state_e;

  localparam logic [3:0] IdDmem  = 4'd0;
  localparam logic [3:0] IdSeg   = 4'd2;
  localparam logic [3:0] IdTimer = 4'd3;
  localparam logic [3:0] IdCmem  = 4'd4;
  localparam logic [3:0] IdKbd   = 4'd5;
  localparam logic [3:0] IdSw    = 4'd6;
  localparam logic [3:0] IdLed   = 4'd7;
  localparam logic [3:0] IdVga   = 4'd8;

  typedef struct packed {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wmask;
  } bus_req_t;

  function automatic logic [3:0] region_id(input logic [31:0] addr);
    return addr[23:20];
  endfunction

endpackage

// File: rtl/mmio_bus_arbiter_rr_arb2.sv
// Two-way round-robin grant; the parent owns the last-granted pointer.
module mmio_bus_arbiter_rr_arb2 (
  input  logic [1:0] req,
  input  logic       last,
  output logic [1:0] gnt
);

  always_comb begin
    gnt = 2'b00;
    case (req)
      2'b01:   gnt = 2'b01;
      2'b10:   gnt = 2'b10;
      // Tie goes to whichever master was not granted last.
      2'b11:   gnt = last ? 2'b01 : 2'b10;
      default: gnt = 2'b00;
    endcase
  end

endmodule

// File: rtl/mmio_bus_arbiter.sv
// Shares the MMIO data bus between the CPU port (m0) and a secondary master (m1),
// one transaction in flight, round-robin grant, per-region read wait states.
module mmio_bus_arbiter #(
  parameter int unsigned RD_LAT   = 1,
  parameter logic [15:0] SLOW_IDS = 16'h0011
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        m0_req,
  input  logic        m0_we,
  input  logic [31:0] m0_addr,
  input  logic [31:0] m0_wdata,
  input  logic [3:0]  m0_wmask,
  output logic        m0_ack,
  output logic [31:0] m0_rdata,
  input  logic        m1_req,
  input  logic        m1_we,
  input  logic [31:0] m1_addr,
  input  logic [31:0] m1_wdata,
  input  logic [3:0]  m1_wmask,
  output logic        m1_ack,
  output logic [31:0] m1_rdata,
  output logic        bus_valid,
  output logic        bus_we,
  output logic [31:0] bus_addr,
  output logic [31:0] bus_wdata,
  output logic [3:0]  bus_wmask,
  input  logic [31:0] bus_rdata,
  output logic        busy
);
  import mmio_bus_arbiter_pkg::*;

  state_e      state_q, state_d;
  bus_req_t    lat_q, lat_d;
  logic        owner_q, owner_d;
  logic        last_q, last_d;
  logic [2:0]  cnt_q, cnt_d;
  logic [31:0] m0_rdata_q, m0_rdata_d;
  logic [31:0] m1_rdata_q, m1_rdata_d;
  logic [1:0]  gnt;
  logic        sample;

  mmio_bus_arbiter_rr_arb2 u_rr_arb2 (
    .req  ({m1_req, m0_req}),
    .last (last_q),
    .gnt  (gnt)
  );

  always_comb begin
    state_d    = state_q;
    lat_d      = lat_q;
    owner_d    = owner_q;
    last_d     = last_q;
    cnt_d      = cnt_q;
    m0_rdata_d = m0_rdata_q;
    m1_rdata_d = m1_rdata_q;
    sample     = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (gnt[1]) begin
          owner_d = 1'b1;
          lat_d   = '{we: m1_we, addr: m1_addr, wdata: m1_wdata, wmask: m1_wmask};
          state_d = StIssue;
        end else if (gnt[0]) begin
          owner_d = 1'b0;
          lat_d   = '{we: m0_we, addr: m0_addr, wdata: m0_wdata, wmask: m0_wmask};
          state_d = StIssue;
        end
      end
      StIssue: begin
        if (!lat_q.we && SLOW_IDS[region_id(lat_q.addr)]) begin
          cnt_d   = 3'(RD_LAT - 1);
          state_d = StWait;
        end else begin
          sample  = !lat_q.we;
          state_d = StDone;
        end
      end
      StWait: begin
        if (cnt_q == 3'd0) begin
          sample  = 1'b1;
          state_d = StDone;
        end else begin
          cnt_d = cnt_q - 3'd1;
        end
      end
      StDone: begin
        last_d  = owner_q;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
    // Read data lands in the owner's register so it is valid alongside ack in DONE.
    if (sample) begin
      if (owner_q) m1_rdata_d = bus_rdata;
      else         m0_rdata_d = bus_rdata;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= StIdle;
      lat_q      <= '0;
      owner_q    <= 1'b0;
      last_q     <= 1'b1;  // m0 preferred out of reset
      cnt_q      <= 3'd0;
      m0_rdata_q <= 32'd0;
      m1_rdata_q <= 32'd0;
    end else begin
      state_q    <= state_d;
      lat_q      <= lat_d;
      owner_q    <= owner_d;
      last_q     <= last_d;
      cnt_q      <= cnt_d;
      m0_rdata_q <= m0_rdata_d;
      m1_rdata_q <= m1_rdata_d;
    end
  end

  assign bus_valid = (state_q == StIssue);
  assign bus_we    = lat_q.we;
  assign bus_addr  = lat_q.addr;
  assign bus_wdata = lat_q.wdata;
  assign bus_wmask = lat_q.wmask;
  assign busy      = (state_q != StIdle);
  assign m0_ack    = (state_q == StDone) && !owner_q;
  assign m1_ack    = (state_q == StDone) && owner_q;
  assign m0_rdata  = m0_rdata_q;
  assign m1_rdata  = m1_rdata_q;

endmodule

// File: tb/tb_mmio_bus_arbiter.sv
// Self-checking bench: vector table plus ack scoreboard for mmio_bus_arbiter.
module tb_mmio_bus_arbiter;
  import mmio_bus_arbiter_pkg::*;

  localparam logic [15:0] Slow = 16'h0011;

  logic        clk, rst;
  logic        m0_req, m0_we, m0_ack, m1_req, m1_we, m1_ack;
  logic [31:0] m0_addr, m0_wdata, m0_rdata, m1_addr, m1_wdata, m1_rdata;
  logic [3:0]  m0_wmask, m1_wmask, bus_wmask;
  logic        bus_valid, bus_we, busy;
  logic [31:0] bus_addr, bus_wdata, bus_rdata;

  mmio_bus_arbiter dut (
    .clk       (clk),
    .rst       (rst),
    .m0_req    (m0_req),
    .m0_we     (m0_we),
    .m0_addr   (m0_addr),
    .m0_wdata  (m0_wdata),
    .m0_wmask  (m0_wmask),
    .m0_ack    (m0_ack),
    .m0_rdata  (m0_rdata),
    .m1_req    (m1_req),
    .m1_we     (m1_we),
    .m1_addr   (m1_addr),
    .m1_wdata  (m1_wdata),
    .m1_wmask  (m1_wmask),
    .m1_ack    (m1_ack),
    .m1_rdata  (m1_rdata),
    .bus_valid (bus_valid),
    .bus_we    (bus_we),
    .bus_addr  (bus_addr),
    .bus_wdata (bus_wdata),
    .bus_wmask (bus_wmask),
    .bus_rdata (bus_rdata),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        mst;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wmask;
    logic [31:0] rdata;
    int          lat;
  } vec_t;

  typedef struct {
    logic        mst;
    logic [31:0] rdata;
  } exp_t;

  exp_t        sbq[$];
  logic [31:0] model_rdata[2];
  int          n_pass = 0;
  int          n_total = 0;
  vec_t        vecs[7];

  // Device model: fast regions answer in the ISSUE cycle, slow regions only after it.
  function automatic logic [31:0] dev_data(input logic [31:0] a);
    logic [3:0] id;
    id = region_id(a);
    if (a == 32'h0050_0000) return 32'h0000_001C;
    if (a == 32'h0000_0040) return 32'h1234_5678;
    if (id == 4'd1 || id > IdVga) return 32'h0;
    return a ^ 32'h5A5A_0000;
  endfunction

  always_comb begin
    bus_rdata = 32'hCCCC_CCCC;
    if (bus_valid && !Slow[region_id(bus_addr)]) bus_rdata = dev_data(bus_addr);
    else if (busy && !bus_valid && Slow[region_id(bus_addr)]) bus_rdata = dev_data(bus_addr);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
  endtask

  always @(negedge clk) begin
    if (!rst && (m0_ack || m1_ack)) begin
      exp_t e;
      check("ack_onehot", 32'(m0_ack & m1_ack), 32'd0);
      if (sbq.size() == 0) begin
        check("unexpected_ack", {30'd0, m1_ack, m0_ack}, 32'd0);
      end else begin
        e = sbq.pop_front();
        check("ack_owner", 32'(m1_ack), 32'(e.mst));
        check("ack_rdata", m1_ack ? m1_rdata : m0_rdata, e.rdata);
        model_rdata[e.mst] = e.rdata;
        check("other_rdata_hold", e.mst ? m0_rdata : m1_rdata, model_rdata[!e.mst]);
      end
    end
  end

  task automatic drive(input vec_t v, input logic on);
    if (v.mst) begin
      m1_req = on; m1_we = v.we; m1_addr = v.addr; m1_wdata = v.wdata; m1_wmask = v.wmask;
    end else begin
      m0_req = on; m0_we = v.we; m0_addr = v.addr; m0_wdata = v.wdata; m0_wmask = v.wmask;
    end
  endtask

  function automatic exp_t expect_of(input vec_t v);
    exp_t e;
    e.mst   = v.mst;
    e.rdata = v.we ? model_rdata[v.mst] : v.rdata;
    return e;
  endfunction

  // One isolated transaction; called at a negedge with the DUT idle.
  task automatic run_one(input vec_t v, input bit drop_early);
    int ack_cyc = 0, n_ack = 0, n_valid = 0, n_busy = 0;
    logic ack;
    sbq.push_back(expect_of(v));
    drive(v, 1'b1);
    for (int c = 1; c <= 10; c++) begin
      @(negedge clk);
      if (c == 1) begin
        check("issue_valid", 32'(bus_valid), 32'd1);
        check("issue_we", 32'(bus_we), 32'(v.we));
        check("issue_addr", bus_addr, v.addr);
        check("issue_wdata", bus_wdata, v.wdata);
        check("issue_wmask", 32'(bus_wmask), 32'(v.wmask));
        if (drop_early) drive(v, 1'b0);
      end
      n_valid += int'(bus_valid);
      n_busy  += int'(busy);
      ack = v.mst ? m1_ack : m0_ack;
      if (ack) begin
        n_ack++;
        if (ack_cyc == 0) ack_cyc = c;
        drive(v, 1'b0);
      end
    end
    check("ack_latency", 32'(ack_cyc), 32'(v.lat));
    check("ack_count", 32'(n_ack), 32'd1);
    check("valid_count", 32'(n_valid), 32'd1);
    check("busy_cycles", 32'(n_busy), 32'(v.lat));
  endtask

  initial begin
    vec_t va, vb;
    int   n_ack, prev_c;
    vecs[0] = '{1'b0, 1'b1, 32'h0020_0000, 32'hDEAD_BEEF, 4'hF, 32'h0, 2};
    vecs[1] = '{1'b1, 1'b0, 32'h0050_0000, 32'h0, 4'h0, 32'h0000_001C, 2};
    vecs[2] = '{1'b0, 1'b0, 32'h0000_0040, 32'h0, 4'h0, 32'h1234_5678, 3};
    vecs[3] = '{1'b0, 1'b0, 32'h00F0_0000, 32'h0, 4'h0, 32'h0, 2};
    vecs[4] = '{1'b0, 1'b0, 32'h0060_0000, 32'h1111_2222, 4'h3, 32'h5A3A_0000, 2};
    vecs[5] = '{1'b1, 1'b1, 32'h0070_0004, 32'h0000_00A5, 4'h1, 32'h0, 2};
    vecs[6] = '{1'b1, 1'b0, 32'h0040_0010, 32'h0, 4'h0, 32'h5A1A_0010, 3};

    rst = 1'b1;
    m0_req = 0; m0_we = 0; m0_addr = 0; m0_wdata = 0; m0_wmask = 0;
    m1_req = 0; m1_we = 0; m1_addr = 0; m1_wdata = 0; m1_wmask = 0;
    model_rdata[0] = 32'h0;
    model_rdata[1] = 32'h0;
    repeat (2) @(negedge clk);
    check("reset_ctrl", {27'd0, bus_valid, bus_we, busy, m0_ack, m1_ack}, 32'd0);
    check("reset_addr", bus_addr, 32'd0);
    check("reset_wdata", bus_wdata | {28'd0, bus_wmask}, 32'd0);
    check("reset_rdata", m0_rdata | m1_rdata, 32'd0);
    rst = 1'b0;
    @(negedge clk);

    foreach (vecs[i]) begin
      run_one(vecs[i], 1'b0);
    end

    // Both masters hold requests: grants must alternate starting with m0.
    va = '{1'b0, 1'b0, 32'h0030_0000, 32'h0, 4'h0, 32'h5A6A_0000, 2};
    vb = '{1'b1, 1'b0, 32'h0030_0000, 32'h0, 4'h0, 32'h5A6A_0000, 2};
    for (int k = 0; k < 4; k++) sbq.push_back(expect_of((k % 2 == 0) ? va : vb));
    drive(va, 1'b1);
    drive(vb, 1'b1);
    n_ack  = 0;
    prev_c = 0;
    for (int c = 1; c <= 20 && n_ack < 4; c++) begin
      @(negedge clk);
      if (m0_ack || m1_ack) begin
        n_ack++;
        if (n_ack > 1) check("rr_spacing", 32'(c - prev_c), 32'd3);
        prev_c = c;
        if (n_ack == 4) begin
          drive(va, 1'b0);
          drive(vb, 1'b0);
        end
      end
    end
    check("rr_ack_total", 32'(n_ack), 32'd4);
    @(negedge clk);
    check("rr_idle_after", 32'(busy), 32'd0);
    @(negedge clk);

    // m0 drops its request right after ISSUE.
    run_one('{1'b0, 1'b0, 32'h0060_0004, 32'h0, 4'h0, 32'h5A3A_0004, 2}, 1'b1);

    // Reset during WAIT of a slow read aborts the transaction silently.
    va = '{1'b0, 1'b0, 32'h0000_0040, 32'h0, 4'h0, 32'h0, 3};
    drive(va, 1'b1);
    @(negedge clk);
    @(negedge clk);
    check("wait_busy", 32'(busy), 32'd1);
    rst = 1'b1;
    #1;
    check("rst_mid_ctrl", {29'd0, bus_valid, busy, m0_ack}, 32'd0);
    check("rst_mid_rdata", m0_rdata, 32'd0);
    drive(va, 1'b0);
    model_rdata[0] = 32'h0;
    model_rdata[1] = 32'h0;
    @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    check("post_rst_idle", 32'(busy), 32'd0);
    run_one('{1'b1, 1'b0, 32'h0050_0000, 32'h0, 4'h0, 32'h0000_001C, 2}, 1'b0);

    check("sb_drained", 32'(sbq.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1);
  end

endmodule
